// File: rtl/display_readout_pkg.sv
// Shared types, constants and the 7-segment glyph table for the decimal readout.
package display_readout_pkg;

  localparam int unsigned VALUE_W     = 32;
  localparam int unsigned NDIGITS_DEF = 10;
  localparam int unsigned NHEX        = 6;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned RAW_W       = 24;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  // Active-low gfedcba glyphs for 0-F.
  function automatic logic [SEG_W-1:0] seg_of(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_readout_if.sv
// Request/response handshake between a value producer and the readout.
interface display_readout_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             ready;
  logic             done;

  modport master (output value, valid, input ready, done);
  modport slave  (input value, valid, output ready, done);
endinterface

// File: rtl/display_readout_seg7_encode.sv
// Combinational nibble to active-low 7-segment glyph with forced blanking.
module seg7_encode
  import display_readout_pkg::*;
(
  input  logic [3:0]       nib_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = seg_of(nib_i);
    if (blank_i) seg_c = SEG_BLANK;
  end

endmodule

// File: rtl/display_readout.sv
// Sequential double-dabble binary to BCD converter feeding a windowed
// six-digit 7-segment readout with leading-zero blanking.
module display_readout
  import display_readout_pkg::*;
#(
  parameter int unsigned WIDTH    = VALUE_W,
  parameter int unsigned NDIGITS  = NDIGITS_DEF,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  display_readout_if.slave          bus,
  input  logic [1:0]                win_sel,
  output logic [NHEX-1:0][SEG_W-1:0] hex
);

  localparam int unsigned BCD_W = NDIGITS * 4;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t                      state_q, state_d;
  logic [WIDTH-1:0]            shreg_q, shreg_d;
  logic [BCD_W-1:0]            bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [RAW_W-1:0]            val_q, val_d;
  logic [BCD_W-1:0]            digits_q, digits_d;
  logic [RAW_W-1:0]            raw_q, raw_d;
  logic                        have_q, have_d;
  logic                        ready_q, ready_d;
  logic                        done_q, done_d;
  logic [NHEX-1:0][SEG_W-1:0]  hex_q, hex_d;

  logic [NDIGITS-1:0]          lz;
  logic [NHEX-1:0][3:0]        nib_w;
  logic [NHEX-1:0]             blank_w;

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign hex       = hex_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      val_q    <= '0;
      digits_q <= '0;
      raw_q    <= '0;
      have_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      hex_q    <= {NHEX{SEG_BLANK}};
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      digits_q <= digits_d;
      raw_q    <= raw_d;
      have_q   <= have_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      hex_q    <= hex_d;
    end
  end

  // Conversion FSM: accept, shift-add-3 for WIDTH cycles, then commit.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    digits_d = digits_q;
    raw_d    = raw_q;
    have_d   = have_q;
    done_d   = 1'b0;
    bcd_adj  = bcd_q;

    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (bus.valid && ready_q) begin
          state_d = CONV;
          shreg_d = bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          val_d   = bus.value[RAW_W-1:0];
        end
      end
      CONV: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        digits_d = bcd_q;
        raw_d    = val_q;
        have_d   = 1'b1;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // lz[k]: digit k and every more-significant digit are zero.
  always_comb begin
    lz = '0;
    lz[NDIGITS-1] = (digits_q[(NDIGITS-1)*4 +: 4] == 4'd0);
    for (int k = int'(NDIGITS) - 2; k >= 0; k--) begin
      lz[k] = lz[k+1] && (digits_q[k*4 +: 4] == 4'd0);
    end
  end

  // Window select; nothing is shown until the first conversion commits.
  always_comb begin
    nib_w   = '0;
    blank_w = '0;
    for (int p = 0; p < int'(NHEX); p++) begin
      case (win_sel)
        2'd0: begin
          nib_w[p]   = digits_q[p*4 +: 4];
          blank_w[p] = BLANK_LZ && (p != 0) && lz[p];
        end
        2'd1: begin
          nib_w[p]   = digits_q[(p+2)*4 +: 4];
          blank_w[p] = BLANK_LZ && (p != 0) && lz[p+2];
        end
        2'd2: begin
          nib_w[p]   = digits_q[(p+4)*4 +: 4];
          blank_w[p] = BLANK_LZ && (p != 0) && lz[p+4];
        end
        default: begin
          nib_w[p]   = raw_q[p*4 +: 4];
          blank_w[p] = 1'b0;
        end
      endcase
      if (!have_q) blank_w[p] = 1'b1;
    end
  end

  for (genvar g = 0; g < int'(NHEX); g++) begin : g_seg
    seg7_encode u_seg (
      .nib_i   (nib_w[g]),
      .blank_i (blank_w[g]),
      .seg_c   (hex_d[g])
    );
  end

endmodule

// File: doc/display_readout.md
Name: display_readout

Overview:
- Converts a 32-bit unsigned value (the PWM value or the user target) to decimal and drives six active-low 7-segment displays (HEX5..HEX0).
- It is the user-facing read side of the switch control path: `control` turns switches into a 32-bit number, and `display_readout` turns a 32-bit number back into digits.
- It uses a sequential shift-add-3 (double dabble) converter with a valid/ready handshake, plus a switch-selected digit window.

Parameters:
- WIDTH, 32, input value width in bits; also the number of conversion iterations.
- NDIGITS, 10, number of BCD digits held; 10 covers 4'294'967'295.
- BLANK_LZ, 1, 1 = blank leading zeros in the displayed window; the least significant shown digit is never blanked.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- value  in  WIDTH  number to display; sampled on the accepted handshake.
- valid  in  1  request conversion of value.
- ready  out  1  high when idle and able to accept a request.
- win_sel  in  2  display window (driven from sw[7:6]).
- done  out  1  one-cycle pulse when new digits are committed.
- hex  out  6x7  hex[k] drives HEXk; active-low segments, bit order gfedcba.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state IDLE, ready=1, done=0;
  - digit store all zero;
  - all hex = 7'h7F (all segments off).
- Reset mid-conversion aborts the conversion; the digit store is not updated.
- The handshake is accepted on a clk edge when valid && ready.
  - value is captured into a shift register, and the BCD accumulator is cleared.
  - valid while ready=0 is ignored and is not queued.
- FSM states: IDLE -> CONV -> COMMIT -> IDLE.
  - IDLE: ready=1. Go to CONV on accept.
  - CONV: ready=0. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, shreg} left by 1. A 5-bit iteration counter runs 0..WIDTH-1. Go to COMMIT after iteration WIDTH-1 (32 CONV cycles).
  - COMMIT: ready=0. Copy the accumulator into the digit store and pulse done=1 for one cycle. Next state IDLE.
- Latency:
  - accept at edge N; done high during cycle N+33; digit store valid from edge N+33;
  - hex reflects the new digits after edge N+34;
  - throughput is one conversion per 34 cycles.
- The BCD accumulator is NDIGITS*4 = 40 bits. No nibble exceeds 9 after any iteration, and the maximum input never overflows the accumulator.
- Digit window (d0 = least significant), registered; changing win_sel updates hex after one edge:
  - 0: hex5..hex0 = d5..d0
  - 1: d7..d2
  - 2: d9..d4
  - 3: raw hexadecimal of the stored value[23:0] (nibbles 5..0, glyphs 0-9 and A-F); leading-zero blanking is not applied.
- Leading-zero blanking (BLANK_LZ=1, windows 0-2):
  - a digit is blanked (7'h7F) if it and all more-significant digits of the full 10-digit number are 0;
  - hex0 of the window is always shown;
  - if every shown digit is a leading zero, only hex0 shows "0".
  - A value with non-zero digits above the window displays those window digits unblanked, zeros included.
- Only the digit store is updated on commit, and the raw value register is updated at the same edge, so hex never shows a half-converted number.
- An accept in the same cycle as a win_sel change is legal; the two are independent.

Decomposition:
- display_pkg holds:
  - typedef state_t enum {IDLE, CONV, COMMIT};
  - localparams SEG_BLANK=7'h7F and the NDIGITS default;
  - function seg_of(4-bit) returning the active-low gfedcba glyph for 0-F.
- Sub-module seg7_encode: combinational 4-bit to 7-bit, with a blank input. It is instantiated 6 times on the window path.
- The conversion FSM and window mux stay in display_readout.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles -> hex all 7'h7F, ready=1, done=0. Release, no valid -> outputs unchanged.
2. value=1'234'554'321 (0x4995CDD1), win_sel=0 -> done at accept+33.
   - hex5..0 = 5,5,4,3,2,1 = 7'h12,7'h12,7'h19,7'h30,7'h24,7'h79.
   - Then win_sel=2 -> next edge shows 1,2,3,4,5,5.
3. value=0, win_sel=0, BLANK_LZ=1 -> hex5..1 = 7'h7F, hex0 = 7'h40. Then value=4'294'967'295, win_sel=1 -> 9,4,9,6,7,2.
4. value=0x00ABCDEF, win_sel=3 -> hex5..0 = A,B,C,D,E,F. Then value=1000 in window 0 -> two blank digits then 1,0,0,0 (7'h79,7'h40,7'h40,7'h40).
5. Assert valid continuously with value changing each cycle -> ready low for 34 cycles after the accept. Only values sampled when ready=1 are displayed, and done pulses exactly once per accept.
6. Accept 12345, pull rst_n low at CONV iteration 10 -> after reset hex=7'h7F, done never pulses. A fresh accept of 12345 then displays it correctly.
